fx2_slave_fifo_responder: RTL and testbench

- Synthesizable responder for the CY68013 (FX2) slave-FIFO bus, in asynchronous-strobe mode.
- Responds to the FPGA-side master's SLCS/SLOE/SLRD/SLWR/FIFOADDR strobes, drives the FD bus and the FLAGA/B/C pins.
- Holds two internal FIFOs:
  - EP2: host→master. Written from the local push port, read by the master at FIFOADDR=00.
  - EP6: master→host. Written by the master at FIFOADDR=10, drained by the local pop port.
- Used for loopback and bring-up without the FX2 device fitted.

---
 rtl/fx2_slave_fifo_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_fx2_slave_fifo_responder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_slave_fifo_responder.sv
// -----------------------------------------------------------------------------
// fx2_slave_fifo_responder
//
// Stand-in for a CY68013 (FX2) slave-FIFO interface in asynchronous-strobe
// mode, so that the FPGA-side master can be brought up or looped back
// without the device fitted. It holds two FIFOs:
//   EP2 : host -> master. Filled from the local push port, read by the
//         master at FIFOADDR=00.
//   EP6 : master -> host. Written by the master at FIFOADDR=10, drained by
//         the local pop port.
//
// Ports
//   fpga_gclk, reset_n          clock, asynchronous active-low reset
//   usb_fifoaddr, usb_slcs,     master strobes (strobes active-low)
//   usb_sloe, usb_slrd, usb_slwr
//   usb_fd                      bidirectional FIFO data bus
//   usb_flaga                   EP2 not empty (registered)
//   usb_flagb                   EP4 not empty, always 0
//   usb_flagc                   EP6 not full (registered)
//   h_wr_valid/data/ready       local push into EP2
//   h_rd_valid/data/ready       local pop from EP6 (show-ahead head entry)
//   err_flags[1:0]              only with FX2_SLAVE_ERR_EN defined:
//                               bit0 EP2 underflow, bit1 EP6 overflow (sticky)
//
// Optional feature macro: FX2_SLAVE_ERR_EN
// -----------------------------------------------------------------------------
module fx2_slave_fifo_responder #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              fpga_gclk,
    input  logic              reset_n,
    input  logic [1:0]        usb_fifoaddr,
    input  logic              usb_slcs,
    input  logic              usb_sloe,
    input  logic              usb_slrd,
    input  logic              usb_slwr,
    inout  wire  [DATA_W-1:0] usb_fd,
    output logic              usb_flaga,
    output logic              usb_flagb,
    output logic              usb_flagc,
    input  logic              h_wr_valid,
    input  logic [DATA_W-1:0] h_wr_data,
    output logic              h_wr_ready,
    output logic              h_rd_valid,
    output logic [DATA_W-1:0] h_rd_data,
    input  logic              h_rd_ready
`ifdef FX2_SLAVE_ERR_EN
    ,
    output logic [1:0]        err_flags
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned IDX_W = DEPTH_LOG2;

    localparam logic [1:0] ADDR_EP2 = 2'b00;
    localparam logic [1:0] ADDR_EP6 = 2'b10;

    // ------------------------------------------------------------------
    // Input sampling and strobe edge detection
    // ------------------------------------------------------------------
    logic              s_slcs;
    logic              s_slrd;
    logic              s_slwr;
    logic [1:0]        s_fifoaddr;
    logic [DATA_W-1:0] s_fd;
    logic              p_slrd;
    logic              p_slwr;
    logic              s_valid;
    logic              rd_armed;
    logic              wr_armed;

    // s_valid marks that the s_* stage holds a real pin sample rather than
    // the reset preset. A strobe only arms once it has been seen high on a
    // real sample, so a strobe held low across reset release cannot produce
    // a rising edge until it has gone high and low again.
    always_ff @(posedge fpga_gclk or negedge reset_n) begin : in_sample
        if (!reset_n) begin
            s_slcs     <= 1'b1;
            s_slrd     <= 1'b1;
            s_slwr     <= 1'b1;
            s_fifoaddr <= 2'b00;
            s_fd       <= '0;
            p_slrd     <= 1'b1;
            p_slwr     <= 1'b1;
            s_valid    <= 1'b0;
            rd_armed   <= 1'b0;
            wr_armed   <= 1'b0;
        end else begin
            s_slcs     <= usb_slcs;
            s_slrd     <= usb_slrd;
            s_slwr     <= usb_slwr;
            s_fifoaddr <= usb_fifoaddr;
            s_fd       <= usb_fd;
            p_slrd     <= s_slrd;
            p_slwr     <= s_slwr;
            s_valid    <= 1'b1;
            if (s_valid && s_slrd) begin
                rd_armed <= 1'b1;
            end
            if (s_valid && s_slwr) begin
                wr_armed <= 1'b1;
            end
        end
    end

    // Transfers complete on the rising (trailing) edge of the strobe.
    logic rd_edge;
    logic wr_edge;

    assign rd_edge = rd_armed && !p_slrd && s_slrd && !s_slcs && (s_fifoaddr == ADDR_EP2);
    assign wr_edge = wr_armed && !p_slwr && s_slwr && !s_slcs && (s_fifoaddr == ADDR_EP6);

    // ------------------------------------------------------------------
    // EP2: local push, master pop
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ep2_mem [DEPTH];
    logic [PTR_W-1:0]  ep2_wr_ptr;
    logic [PTR_W-1:0]  ep2_rd_ptr;
    logic              ep2_empty;
    logic              ep2_full;
    logic              ep2_push;
    logic              ep2_pop;

    assign ep2_empty = (ep2_wr_ptr == ep2_rd_ptr);
    assign ep2_full  = (ep2_wr_ptr[PTR_W-1] != ep2_rd_ptr[PTR_W-1]) &&
                       (ep2_wr_ptr[IDX_W-1:0] == ep2_rd_ptr[IDX_W-1:0]);
    assign ep2_push  = h_wr_valid && !ep2_full;
    assign ep2_pop   = rd_edge && !ep2_empty;

    // EP2 storage write
    always_ff @(posedge fpga_gclk) begin : ep2_store
        if (ep2_push) begin
            ep2_mem[ep2_wr_ptr[IDX_W-1:0]] <= h_wr_data;
        end
    end

    // EP2 pointers
    always_ff @(posedge fpga_gclk or negedge reset_n) begin : ep2_ptrs
        if (!reset_n) begin
            ep2_wr_ptr <= '0;
            ep2_rd_ptr <= '0;
        end else begin
            if (ep2_push) begin
                ep2_wr_ptr <= ep2_wr_ptr + PTR_W'(1);
            end
            if (ep2_pop) begin
                ep2_rd_ptr <= ep2_rd_ptr + PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // EP6: master push, local pop
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ep6_mem [DEPTH];
    logic [PTR_W-1:0]  ep6_wr_ptr;
    logic [PTR_W-1:0]  ep6_rd_ptr;
    logic              ep6_empty;
    logic              ep6_full;
    logic              ep6_push;
    logic              ep6_pop;

    assign ep6_empty = (ep6_wr_ptr == ep6_rd_ptr);
    assign ep6_full  = (ep6_wr_ptr[PTR_W-1] != ep6_rd_ptr[PTR_W-1]) &&
                       (ep6_wr_ptr[IDX_W-1:0] == ep6_rd_ptr[IDX_W-1:0]);
    assign ep6_push  = wr_edge && !ep6_full;
    assign ep6_pop   = !ep6_empty && h_rd_ready;

    // EP6 storage write
    always_ff @(posedge fpga_gclk) begin : ep6_store
        if (ep6_push) begin
            ep6_mem[ep6_wr_ptr[IDX_W-1:0]] <= s_fd;
        end
    end

    // EP6 pointers
    always_ff @(posedge fpga_gclk or negedge reset_n) begin : ep6_ptrs
        if (!reset_n) begin
            ep6_wr_ptr <= '0;
            ep6_rd_ptr <= '0;
        end else begin
            if (ep6_push) begin
                ep6_wr_ptr <= ep6_wr_ptr + PTR_W'(1);
            end
            if (ep6_pop) begin
                ep6_rd_ptr <= ep6_rd_ptr + PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Flags: registered from the current pointer state, so they follow a
    // count change by one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge fpga_gclk or negedge reset_n) begin : flag_regs
        if (!reset_n) begin
            usb_flaga <= 1'b0;
            usb_flagc <= 1'b1;
        end else begin
            usb_flaga <= !ep2_empty;
            usb_flagc <= !ep6_full;
        end
    end

    assign usb_flagb = 1'b0;

    // ------------------------------------------------------------------
    // Local port status (direct views of the FIFO state registers)
    // ------------------------------------------------------------------
    assign h_wr_ready = !ep2_full;
    assign h_rd_valid = !ep6_empty;
    assign h_rd_data  = ep6_empty ? '0 : ep6_mem[ep6_rd_ptr[IDX_W-1:0]];

    // ------------------------------------------------------------------
    // FD bus: driven straight from the raw pins so that SLOE behaves like
    // the device's asynchronous output enable; reset releases it at once.
    // ------------------------------------------------------------------
    logic              fd_drive;
    logic [DATA_W-1:0] fd_out;

    assign fd_drive = reset_n && !usb_slcs && !usb_sloe && (usb_fifoaddr == ADDR_EP2);
    assign fd_out   = ep2_empty ? '0 : ep2_mem[ep2_rd_ptr[IDX_W-1:0]];
    assign usb_fd   = fd_drive ? fd_out : {DATA_W{1'bz}};

`ifdef FX2_SLAVE_ERR_EN
    // ------------------------------------------------------------------
    // Sticky error capture for strobes dropped on empty/full FIFOs
    // ------------------------------------------------------------------
    logic ep2_underflow;
    logic ep6_overflow;

    assign ep2_underflow = rd_edge && ep2_empty;
    assign ep6_overflow  = wr_edge && ep6_full;

    always_ff @(posedge fpga_gclk or negedge reset_n) begin : err_regs
        if (!reset_n) begin
            err_flags <= 2'b00;
        end else begin
            err_flags <= err_flags | {ep6_overflow, ep2_underflow};
        end
    end
`endif

endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// -----------------------------------------------------------------------------
// Testbench for fx2_slave_fifo_responder: a directed vector table, hand
// sequences for the full/wrap/reset corners, then random traffic checked
// against queue-based FIFO models.
// -----------------------------------------------------------------------------
module tb_fx2_slave_fifo_responder;

    localparam int unsigned DW = 16;

    logic          fpga_gclk;
    logic          reset_n;
    logic [1:0]    usb_fifoaddr;
    logic          usb_slcs;
    logic          usb_sloe;
    logic          usb_slrd;
    logic          usb_slwr;
    wire  [DW-1:0] usb_fd;
    logic          usb_flaga;
    logic          usb_flagb;
    logic          usb_flagc;
    logic          h_wr_valid;
    logic [DW-1:0] h_wr_data;
    logic          h_wr_ready;
    logic          h_rd_valid;
    logic [DW-1:0] h_rd_data;
    logic          h_rd_ready;
`ifdef FX2_SLAVE_ERR_EN
    logic [1:0]    err_flags;
`endif

    logic [DW-1:0] tb_fd;
    logic          tb_fd_en;
    assign usb_fd = tb_fd_en ? tb_fd : {DW{1'bz}};

    fx2_slave_fifo_responder #(.DEPTH_LOG2(4), .DATA_W(DW)) dut (
        .fpga_gclk    (fpga_gclk),
        .reset_n      (reset_n),
        .usb_fifoaddr (usb_fifoaddr),
        .usb_slcs     (usb_slcs),
        .usb_sloe     (usb_sloe),
        .usb_slrd     (usb_slrd),
        .usb_slwr     (usb_slwr),
        .usb_fd       (usb_fd),
        .usb_flaga    (usb_flaga),
        .usb_flagb    (usb_flagb),
        .usb_flagc    (usb_flagc),
        .h_wr_valid   (h_wr_valid),
        .h_wr_data    (h_wr_data),
        .h_wr_ready   (h_wr_ready),
        .h_rd_valid   (h_rd_valid),
        .h_rd_data    (h_rd_data),
        .h_rd_ready   (h_rd_ready)
`ifdef FX2_SLAVE_ERR_EN
        ,
        .err_flags    (err_flags)
`endif
    );

    initial fpga_gclk = 1'b0;
    always #10 fpga_gclk = ~fpga_gclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues plus sticky error bits.
    logic [DW-1:0] q2[$];
    logic [DW-1:0] q6[$];
    logic [1:0]    m_err;

    typedef enum int {OP_LPUSH, OP_LPOP, OP_MWRITE, OP_MREAD,
                      OP_MREAD_NOCS, OP_MWRITE_NOCS, OP_MWRITE_A01} op_t;

    typedef struct {
        op_t           op;
        logic [DW-1:0] data;
        logic          chk_val;
        logic [DW-1:0] exp_val;
        logic          exp_flaga;
        logic          exp_flagc;
        logic          exp_rdv;
        logic [DW-1:0] exp_rdd;
        logic          exp_wrr;
        logic [1:0]    exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A released bus reads as Z (or 0 on two-state simulators).
    task automatic check_fd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (!((act === exp) || (exp == '0 && act === {DW{1'bz}}))) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fpga_gclk);
            #1;
        end
    endtask

    task automatic idle_bus();
        usb_fifoaddr = 2'b00;
        usb_slcs     = 1'b1;
        usb_sloe     = 1'b1;
        usb_slrd     = 1'b1;
        usb_slwr     = 1'b1;
        tb_fd_en     = 1'b0;
        tb_fd        = '0;
        h_wr_valid   = 1'b0;
        h_wr_data    = '0;
        h_rd_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        q2.delete();
        q6.delete();
        m_err = 2'b00;
    endtask

    task automatic lpush(input logic [DW-1:0] d);
        h_wr_valid = 1'b1;
        h_wr_data  = d;
        tick(1);
        h_wr_valid = 1'b0;
        tick(3);
    endtask

    task automatic lpop(output logic [DW-1:0] d);
        d = h_rd_data;
        h_rd_ready = 1'b1;
        tick(1);
        h_rd_ready = 1'b0;
        tick(3);
    endtask

    task automatic mwrite(input logic [1:0] addr, input logic cs, input logic [DW-1:0] d);
        usb_fifoaddr = addr;
        usb_slcs     = cs;
        tb_fd        = d;
        tb_fd_en     = 1'b1;
        tick(2);
        usb_slwr = 1'b0;
        tick(2);
        usb_slwr = 1'b1;
        tick(2);
        tb_fd_en     = 1'b0;
        usb_slcs     = 1'b1;
        usb_fifoaddr = 2'b00;
        tick(3);
    endtask

    task automatic mread(input logic cs, output logic [DW-1:0] v);
        usb_fifoaddr = 2'b00;
        usb_slcs     = cs;
        usb_sloe     = 1'b0;
        tb_fd_en     = 1'b0;
        tick(2);
        v = usb_fd;
        usb_slrd = 1'b0;
        tick(2);
        usb_slrd = 1'b1;
        tick(3);
        usb_sloe = 1'b1;
        usb_slcs = 1'b1;
        tick(2);
    endtask

    task automatic run_op(input op_t op, input logic [DW-1:0] d, output logic [DW-1:0] v);
        v = '0;
        case (op)
            OP_LPUSH:       lpush(d);
            OP_LPOP:        lpop(v);
            OP_MWRITE:      mwrite(2'b10, 1'b0, d);
            OP_MREAD:       mread(1'b0, v);
            OP_MREAD_NOCS:  mread(1'b1, v);
            OP_MWRITE_NOCS: mwrite(2'b10, 1'b1, d);
            OP_MWRITE_A01:  mwrite(2'b01, 1'b0, d);
            default:        v = '0;
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, " flaga"}, 32'(usb_flaga), 32'(q2.size() != 0));
        check({tag, " flagb"}, 32'(usb_flagb), 32'd0);
        check({tag, " flagc"}, 32'(usb_flagc), 32'(q6.size() != 16));
        check({tag, " rd_valid"}, 32'(h_rd_valid), 32'(q6.size() != 0));
        check({tag, " rd_data"}, 32'(h_rd_data), (q6.size() != 0) ? 32'(q6[0]) : 32'd0);
        check({tag, " wr_ready"}, 32'(h_wr_ready), 32'(q2.size() < 16));
`ifdef FX2_SLAVE_ERR_EN
        check({tag, " err_flags"}, 32'(err_flags), 32'(m_err));
`endif
    endtask

    initial begin : watchdog
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [DW-1:0] v;
        int next_push;

        vecs[0]  = '{OP_LPUSH,       16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b00};
        vecs[1]  = '{OP_MREAD,       16'h0000, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b00};
        vecs[2]  = '{OP_MREAD,       16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[3]  = '{OP_MWRITE,      16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 2'b01};
        vecs[4]  = '{OP_LPOP,        16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[5]  = '{OP_LPUSH,       16'h00A5, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[6]  = '{OP_MREAD_NOCS,  16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[7]  = '{OP_MWRITE_A01,  16'h5555, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[8]  = '{OP_MWRITE_NOCS, 16'h7777, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[9]  = '{OP_MREAD,       16'h0000, 1'b1, 16'h00A5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[10] = '{OP_MWRITE,      16'h0042, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b1, 2'b01};
        vecs[11] = '{OP_LPUSH,       16'h0099, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0042, 1'b1, 2'b01};
        vecs[12] = '{OP_LPOP,        16'h0000, 1'b1, 16'h0042, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};
        vecs[13] = '{OP_MREAD,       16'h0000, 1'b1, 16'h0099, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01};

        // Reset state
        do_reset();
        check("reset flaga", 32'(usb_flaga), 32'd0);
        check("reset flagb", 32'(usb_flagb), 32'd0);
        check("reset flagc", 32'(usb_flagc), 32'd1);
        check("reset wr_ready", 32'(h_wr_ready), 32'd1);
        check("reset rd_valid", 32'(h_rd_valid), 32'd0);
        check("reset rd_data", 32'(h_rd_data), 32'd0);
        check_fd("reset fd released", usb_fd, 16'h0000);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].data, v);
            if (vecs[i].chk_val) begin
                check_fd($sformatf("vec%0d value", i), v, vecs[i].exp_val);
            end
            check($sformatf("vec%0d flaga", i), 32'(usb_flaga), 32'(vecs[i].exp_flaga));
            check($sformatf("vec%0d flagc", i), 32'(usb_flagc), 32'(vecs[i].exp_flagc));
            check($sformatf("vec%0d rd_valid", i), 32'(h_rd_valid), 32'(vecs[i].exp_rdv));
            check($sformatf("vec%0d rd_data", i), 32'(h_rd_data), 32'(vecs[i].exp_rdd));
            check($sformatf("vec%0d wr_ready", i), 32'(h_wr_ready), 32'(vecs[i].exp_wrr));
`ifdef FX2_SLAVE_ERR_EN
            check($sformatf("vec%0d err_flags", i), 32'(err_flags), 32'(vecs[i].exp_err));
`endif
        end

        // Push into empty EP2 raises flaga exactly two cycles later;
        // SLOE high keeps FD released.
        do_reset();
        h_wr_valid = 1'b1;
        h_wr_data  = 16'h1234;
        tick(1);
        h_wr_valid = 1'b0;
        check("lat flaga +1", 32'(usb_flaga), 32'd0);
        tick(1);
        check("lat flaga +2", 32'(usb_flaga), 32'd1);
        usb_fifoaddr = 2'b00;
        usb_slcs     = 1'b0;
        #2;
        check_fd("fd sloe high released", usb_fd, 16'h0000);
        usb_sloe = 1'b0;
        #2;
        check("fd sloe low head", 32'(usb_fd), 32'h1234);
        usb_fifoaddr = 2'b10;
        #2;
        check_fd("fd addr10 released", usb_fd, 16'h0000);
        idle_bus();
        tick(2);

        // EP6 fill to full, overflow, in-order drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mwrite(2'b10, 1'b0, DW'(16'hA000 + i));
            if (i == 14) begin
                check("ep6 15 flagc", 32'(usb_flagc), 32'd1);
            end
        end
        check("ep6 16 flagc", 32'(usb_flagc), 32'd0);
        check("ep6 16 rd_valid", 32'(h_rd_valid), 32'd1);
        mwrite(2'b10, 1'b0, 16'hFFFF);
        check("ep6 17 flagc", 32'(usb_flagc), 32'd0);
`ifdef FX2_SLAVE_ERR_EN
        check("ep6 overflow err", 32'(err_flags), 32'd2);
`endif
        for (int i = 0; i < 16; i++) begin
            lpop(v);
            check($sformatf("ep6 drain %0d", i), 32'(v), 32'(16'hA000 + i));
            if (i == 0) begin
                check("ep6 flagc after pop", 32'(usb_flagc), 32'd1);
            end
        end
        check("ep6 drained rd_valid", 32'(h_rd_valid), 32'd0);

        // Loopback 0x0000..0x0013 across pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            lpush(DW'(i));
        end
        check("loop wr_ready full", 32'(h_wr_ready), 32'd0);
        check("loop flaga full", 32'(usb_flaga), 32'd1);
        next_push = 16;
        for (int i = 0; i < 20; i++) begin
            logic [DW-1:0] d;
            mread(1'b0, v);
            check_fd($sformatf("loop ep2 %0d", i), v, DW'(i));
            mwrite(2'b10, 1'b0, v);
            lpop(d);
            check($sformatf("loop ep6 %0d", i), 32'(d), 32'(i));
            if (next_push < 20) begin
                lpush(DW'(next_push));
                next_push++;
            end
        end
        check("loop flaga empty", 32'(usb_flaga), 32'd0);
        check("loop rd_valid empty", 32'(h_rd_valid), 32'd0);

        // Reset while the master is driving FD, then mid-SLWR
        do_reset();
        lpush(16'h5A5A);
        usb_fifoaddr = 2'b00;
        usb_slcs     = 1'b0;
        usb_sloe     = 1'b0;
        #2;
        check("rst pre fd head", 32'(usb_fd), 32'h5A5A);
        #3;
        reset_n = 1'b0;
        #1;
        check_fd("rst fd released", usb_fd, 16'h0000);
        check("rst flaga", 32'(usb_flaga), 32'd0);
        idle_bus();
        tick(2);
        reset_n = 1'b1;
        tick(3);
        usb_fifoaddr = 2'b10;
        usb_slcs     = 1'b0;
        tb_fd        = 16'hCAFE;
        tb_fd_en     = 1'b1;
        tick(2);
        usb_slwr = 1'b0;
        tick(1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst slwr flagc", 32'(usb_flagc), 32'd1);
        check("rst slwr flaga", 32'(usb_flaga), 32'd0);
        check("rst slwr rd_valid", 32'(h_rd_valid), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        usb_slwr = 1'b1;
        tick(4);
        idle_bus();
        tick(3);
        check("rst no entry rd_valid", 32'(h_rd_valid), 32'd0);
        check("rst no entry flagc", 32'(usb_flagc), 32'd1);
        mwrite(2'b10, 1'b0, 16'h1111);
        check("rst recover rd_valid", 32'(h_rd_valid), 32'd1);
        check("rst recover rd_data", 32'(h_rd_data), 32'h1111);

        // Random traffic against the queue model
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int r;
            logic [DW-1:0] d;
            logic [DW-1:0] exp_v;
            r = (it < 120) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
            d = DW'($urandom);
            case (r)
                0, 4: begin
                    lpush(d);
                    if (q2.size() < 16) q2.push_back(d);
                end
                1: begin
                    exp_v = (q6.size() != 0) ? q6[0] : '0;
                    lpop(v);
                    check($sformatf("rand%0d lpop", it), 32'(v), 32'(exp_v));
                    if (q6.size() != 0) void'(q6.pop_front());
                end
                2, 5: begin
                    mwrite(2'b10, 1'b0, d);
                    if (q6.size() < 16) q6.push_back(d);
                    else m_err[1] = 1'b1;
                end
                default: begin
                    exp_v = (q2.size() != 0) ? q2[0] : '0;
                    mread(1'b0, v);
                    check_fd($sformatf("rand%0d mread", it), v, exp_v);
                    if (q2.size() != 0) void'(q2.pop_front());
                    else m_err[0] = 1'b1;
                end
            endcase
            check_model($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
